// File: rtl/ring_fifo_pkg.sv
// Shared helpers for the ring FIFO family: pointer arithmetic, depth and
// threshold predicates, and the per-edge write decision type.
package ring_fifo_pkg;

  // Pointer values are zero-extended to this width before arithmetic so one
  // helper serves every instance size.
  localparam int unsigned PtrWordW = 32;

  typedef logic [PtrWordW-1:0] ptr_word_t;

  // What happens to an incoming write on a given edge.
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_DROP,
    WR_OVERWRITE
  } wr_action_t;

  function automatic int unsigned fifo_depth(input int unsigned length_bits);
    return 32'd1 << length_bits;
  endfunction

  // Occupancy is the pointer difference taken modulo 2^ptr_bits; the wrap bit
  // is what separates a full buffer from an empty one.
  function automatic ptr_word_t fifo_count(input ptr_word_t wr, input ptr_word_t rd,
                                           input int unsigned ptr_bits);
    ptr_word_t mask;
    if (ptr_bits >= PtrWordW) mask = '1;
    else mask = (ptr_word_t'(1) << ptr_bits) - ptr_word_t'(1);
    return (wr - rd) & mask;
  endfunction

  // A gap at or beyond the depth keeps the flag permanently asserted rather
  // than letting the unsigned threshold wrap around.
  function automatic logic at_almost_full(input ptr_word_t count, input int unsigned depth,
                                          input int unsigned gap);
    if (gap >= depth) return 1'b1;
    return count >= ptr_word_t'(depth - gap);
  endfunction

  function automatic logic at_almost_empty(input ptr_word_t count, input int unsigned level);
    return count <= ptr_word_t'(level);
  endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// Simple dual-port storage: one write port, one read port with a registered
// output. Neither the array nor the read register is reset, so it maps onto
// block RAM. A read and write to the same address on one edge return the old
// word.
module ring_fifo_mem #(
  parameter int DataW = 8,
  parameter int AddrW = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [DataW-1:0] rd_data
);

  logic [DataW-1:0] mem_reg [0:(1<<AddrW)-1];
  logic [DataW-1:0] rd_data_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  // Registered read port; holds its last value when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/ring_fifo.sv
// Single-clock ring FIFO with read-acknowledge handshake, optional
// drop-oldest overwrite, almost-full/empty thresholds, sticky error flags
// and synchronous flush.
module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter int WordSize         = 8,
  parameter int LengthBits       = 3,
  parameter int OverwriteOnFull  = 0,
  parameter int AlmostFullGap    = 1,
  parameter int AlmostEmptyLevel = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                dataWriteEnable,
  input  logic [WordSize-1:0] dataWrite,
  input  logic                dataReadEnable,
  output logic                dataReadAck,
  output logic [WordSize-1:0] dataRead,
  input  logic                clearErrors,
  output logic [LengthBits:0] bufferLength,
  output logic                full,
  output logic                empty,
  output logic                almostFull,
  output logic                almostEmpty,
  output logic                overflow,
  output logic                underflow
);

  localparam int PtrW = LengthBits + 1;
  localparam int unsigned Depth = fifo_depth(LengthBits);
  localparam logic [PtrW-1:0] DepthCount = PtrW'(Depth);

  logic [PtrW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic                ack_reg, ack_next;
  logic                overflow_reg, overflow_next;
  logic                underflow_reg, underflow_next;
  logic                data_valid_reg;
  ptr_word_t           count_wide;
  logic [PtrW-1:0]     count;
  logic                is_full, is_empty, rd_ok, mem_we;
  wr_action_t          wr_action;
  logic [WordSize-1:0] mem_rd_data;

  assign count_wide = fifo_count(ptr_word_t'(wr_ptr_reg), ptr_word_t'(rd_ptr_reg), PtrW);
  assign count      = count_wide[PtrW-1:0];
  assign is_full    = (count == DepthCount);
  assign is_empty   = (count == '0);

  // A read is served only from words already stored before this edge.
  assign rd_ok = dataReadEnable && !is_empty && !flush;

  // Decide the fate of an incoming write from the pre-edge occupancy.
  always_comb begin
    wr_action = WR_IDLE;
    if (dataWriteEnable && !flush) begin
      if (!is_full || rd_ok)         wr_action = WR_ACCEPT;
      else if (OverwriteOnFull != 0) wr_action = WR_OVERWRITE;
      else                           wr_action = WR_DROP;
    end
  end

  assign mem_we = (wr_action == WR_ACCEPT) || (wr_action == WR_OVERWRITE);

  // Next pointers, handshake and sticky flags; a new error beats clearErrors.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    ack_next       = 1'b0;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush) begin
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (clearErrors) begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
      end
      if (rd_ok) begin
        rd_ptr_next = rd_ptr_reg + PtrW'(1);
        ack_next    = 1'b1;
      end else if (dataReadEnable) begin
        underflow_next = 1'b1;
      end
      case (wr_action)
        WR_ACCEPT: wr_ptr_next = wr_ptr_reg + PtrW'(1);
        WR_OVERWRITE: begin
          wr_ptr_next   = wr_ptr_reg + PtrW'(1);
          rd_ptr_next   = rd_ptr_reg + PtrW'(1);
          overflow_next = 1'b1;
        end
        WR_DROP: overflow_next = 1'b1;
        default: ;
      endcase
    end
  end

  // State registers; data_valid_reg masks the unreset RAM output until the
  // first successful read after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      ack_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      ack_reg        <= ack_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
      data_valid_reg <= data_valid_reg | rd_ok;
    end
  end

  ring_fifo_mem #(
    .DataW(WordSize),
    .AddrW(LengthBits)
  ) u_mem (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_addr(wr_ptr_reg[LengthBits-1:0]),
    .wr_data(dataWrite),
    .rd_en  (rd_ok),
    .rd_addr(rd_ptr_reg[LengthBits-1:0]),
    .rd_data(mem_rd_data)
  );

  assign dataReadAck  = ack_reg;
  assign dataRead     = data_valid_reg ? mem_rd_data : '0;
  assign bufferLength = count;
  assign full         = is_full;
  assign empty        = is_empty;
  assign almostFull   = at_almost_full(count_wide, Depth, AlmostFullGap);
  assign almostEmpty  = at_almost_empty(count_wide, AlmostEmptyLevel);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule
